// File: rtl/nibble_serial_adder.sv
// Bit-serial-by-nibble adder around one shared 4-bit slice; optional signed overflow via NSA_OVERFLOW_EN.
// Latency: result valid NIBBLES cycles after accept, minimum initiation interval NIBBLES+2.
// Backpressure: out_ready low holds DONE with all outputs frozen; in_ready high only in IDLE.

module fa_4bit (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);
    logic [4:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_ci};
    assign o_s    = w_full[3:0];
    assign o_co   = w_full[4];
endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 ci,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 co,
    output logic                 busy
`ifdef NSA_OVERFLOW_EN
    ,
    output logic                 ovf
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_carry;
    logic            r_co;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      w_slice_s;
    logic            w_slice_co;
    logic            w_accept;
    logic            w_last;

    fa_4bit u_slice (
        .i_a  (r_a[3:0]),
        .i_b  (r_b[3:0]),
        .i_ci (r_carry),
        .o_s  (w_slice_s),
        .o_co (w_slice_co)
    );

    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_state == RUN) && (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_carry <= ci;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            // Slice sum enters at the top so the LSB nibble lands at bit 0 after NIBBLES shifts.
            r_a     <= {4'b0000, r_a[W-1:4]};
            r_b     <= {4'b0000, r_b[W-1:4]};
            r_sum   <= {w_slice_s, r_sum[W-1:4]};
            r_carry <= w_slice_co;
            if (w_last) begin
                r_co <= w_slice_co;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

`ifdef NSA_OVERFLOW_EN
    logic r_a_sign;
    logic r_b_sign;
    logic r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sign <= a[W-1];
            r_b_sign <= b[W-1];
            r_ovf    <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_a_sign == r_b_sign) && (w_slice_s[3] != r_a_sign);
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign co        = r_co;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with NIBBLES=4; covers overflow when NSA_OVERFLOW_EN is defined.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        co;
    logic        busy;
`ifdef NSA_OVERFLOW_EN
    logic        ovf;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .busy      (busy)
`ifdef NSA_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Accepts one operation and waits (bounded) for out_valid; returns edges from accept to result.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                          output int lat);
        a        = ta;
        b        = tb_;
        ci       = tci;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_tests++; if (sum !== 16'h0000)   begin n_fail++; $display("FAIL reset_sum got %h want 0000", sum); end
        n_tests++; if (co !== 1'b0)        begin n_fail++; $display("FAIL reset_co got %b want 0", co); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef NSA_OVERFLOW_EN
        n_tests++; if (ovf !== 1'b0)       begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit early = 1'b0;
        out_ready = 1'b1;
        a = 16'h1234; b = 16'h1111; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b in_ready=%b want 1/0", busy, in_ready); end
        for (int j = 1; j <= 3; j++) begin
            if (out_valid !== 1'b0) early = 1'b1;
            tick();
        end
        if (out_valid !== 1'b0) early = 1'b1;
        n_tests++; if (early) begin n_fail++; $display("FAIL basic_early out_valid seen before 4 cycles"); end
        tick();
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency out_valid got %b want 1 at 4 cycles", out_valid); end
        n_tests++; if (sum !== 16'h2345)   begin n_fail++; $display("FAIL basic_sum got %h want 2345", sum); end
        n_tests++; if (co !== 1'b0)        begin n_fail++; $display("FAIL basic_co got %b want 0", co); end
        tick();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        n_tests++; if (sum !== 16'h2345)   begin n_fail++; $display("FAIL basic_held got %h want 2345", sum); end
    endtask

    task automatic test_ripple();
        int lat;
        out_ready = 1'b1;
        run_op(16'hFFFF, 16'h0001, 1'b0, lat);
        n_tests++; if (lat != 4)         begin n_fail++; $display("FAIL ripple1_lat got %0d want 4", lat); end
        n_tests++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL ripple1_sum got %h want 0000", sum); end
        n_tests++; if (co !== 1'b1)      begin n_fail++; $display("FAIL ripple1_co got %b want 1", co); end
        tick();
        run_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
        n_tests++; if (sum !== 16'hFFFF) begin n_fail++; $display("FAIL ripple2_sum got %h want ffff", sum); end
        n_tests++; if (co !== 1'b1)      begin n_fail++; $display("FAIL ripple2_co got %b want 1", co); end
        tick();
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        run_op(16'hF0F0, 16'h1F10, 1'b0, lat);
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b want 1", out_valid); end
        for (int j = 0; j < 3; j++) begin
            a = 16'h5555; b = 16'h5555; ci = 1'b1; in_valid = 1'b1;
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h1000 || co !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d got v=%b rdy=%b sum=%h co=%b want 1/0/1000/1", j, out_valid, in_ready, sum, co);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_tests++; if (sum !== 16'h1000 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_ignored got sum=%h busy=%b want 1000/0", sum, busy); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        out_ready = 1'b1;
        a = 16'hABCD; b = 16'h1234; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || co !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset got rdy=%b v=%b busy=%b sum=%h co=%b want 1/0/0/0000/0", in_ready, out_valid, busy, sum, co);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrun_ready got %b want 1", in_ready); end
        run_op(16'h0001, 16'h0001, 1'b0, lat);
        n_tests++; if (sum !== 16'h0002 || co !== 1'b0) begin n_fail++; $display("FAIL midrun_next got sum=%h co=%b want 0002/0", sum, co); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] qa [3] = '{16'h1234, 16'h8000, 16'h0FFF};
        logic [15:0] qb [3] = '{16'h4321, 16'h8000, 16'h0001};
        logic        qc [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] es [3] = '{16'h5555, 16'h0001, 16'h1000};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        int acc [3];
        int tx = 0;
        int rx = 0;
        out_ready = 1'b1;
        a = qa[0]; b = qb[0]; ci = qc[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && rx < 3; cyc++) begin
            if (out_valid) begin
                n_tests++;
                if (sum !== es[rx] || co !== ec[rx]) begin
                    n_fail++;
                    $display("FAIL b2b_result%0d got sum=%h co=%b want %h/%b", rx, sum, co, es[rx], ec[rx]);
                end
                rx++;
            end
            if (in_ready && in_valid && tx < 3) begin
                acc[tx] = cyc;
                tx++;
            end
            tick();
            if (tx < 3) begin
                a = qa[tx]; b = qb[tx]; ci = qc[tx];
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        n_tests++; if (rx != 3 || tx != 3) begin n_fail++; $display("FAIL b2b_count got rx=%0d tx=%0d want 3/3", rx, tx); end
        if (tx == 3) begin
            n_tests++; if (acc[1] - acc[0] != 6) begin n_fail++; $display("FAIL b2b_gap01 got %0d want 6", acc[1] - acc[0]); end
            n_tests++; if (acc[2] - acc[1] != 6) begin n_fail++; $display("FAIL b2b_gap12 got %0d want 6", acc[2] - acc[1]); end
        end
        tick();
    endtask

`ifdef NSA_OVERFLOW_EN
    task automatic test_overflow();
        int lat;
        out_ready = 1'b1;
        run_op(16'h7FFF, 16'h0001, 1'b0, lat);
        n_tests++; if (sum !== 16'h8000 || co !== 1'b0 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pos got sum=%h co=%b ovf=%b want 8000/0/1", sum, co, ovf); end
        tick();
        run_op(16'h8000, 16'hFFFF, 1'b0, lat);
        n_tests++; if (sum !== 16'h7FFF || co !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_neg got sum=%h co=%b ovf=%b want 7fff/1/1", sum, co, ovf); end
        tick();
        run_op(16'h0005, 16'hFFFB, 1'b0, lat);
        n_tests++; if (sum !== 16'h0000 || co !== 1'b1 || ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_none got sum=%h co=%b ovf=%b want 0000/1/0", sum, co, ovf); end
        tick();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ripple();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef NSA_OVERFLOW_EN
        test_overflow();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
